// File: rtl/cve2_pkg.sv
// Shared constants and helpers for the cve2 core.
//
// OPCODE_C_MASK : the two low opcode bits of a halfword. An instruction
//                 whose low bits are not both set is a 16-bit (compressed)
//                 instruction.
package cve2_pkg;

  localparam logic [1:0] OPCODE_C_MASK = 2'b11;

  // Returns 1 when the halfword opcode bits mark a compressed instruction.
  function automatic logic is_compressed_opc(input logic [1:0] opc);
    return (opc & OPCODE_C_MASK) != OPCODE_C_MASK;
  endfunction

endpackage

// File: rtl/cve2_fetch_fifo.sv
// Instruction fetch FIFO between the instruction bus interface and the
// IF/ID register. It holds whole 32-bit fetch words with their bus error
// flags, tracks the PC of the head instruction, and realigns halfword-aligned
// instructions when compressed support is enabled.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   clear_i          flush all entries, load PC from in_addr_i
//   in_addr_i        new head PC (sampled on clear_i only, bit 0 ignored)
//   in_valid_i       fetch word arriving from the bus
//   in_rdata_i       fetch word
//   in_err_i         bus error for that word
//   count_o          number of occupied word entries (registered)
//   out_valid_o      head instruction available
//   out_ready_i      consumer accepts the head instruction
//   out_addr_o       PC of the head instruction
//   out_rdata_o      head instruction (upper half don't-care if compressed)
//   out_err_o        fetch error on the head instruction
//   out_err_plus2_o  error only in the second half of a straddling instruction
module cve2_fetch_fifo
  import cve2_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter bit RV32C = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [31:0]                in_addr_i,
  input  logic                       in_valid_i,
  input  logic [31:0]                in_rdata_i,
  input  logic                       in_err_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_addr_o,
  output logic [31:0]                out_rdata_o,
  output logic                       out_err_o,
  output logic                       out_err_plus2_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  // Entries are always packed from index 0, so occupancy alone says which
  // entries are valid. Error bits of free entries are kept at zero.
  logic [31:0]      rdata_q [DEPTH];
  logic [31:0]      rdata_d [DEPTH];
  logic [DEPTH-1:0] err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d, cnt_after;
  logic [31:0]      pc_q, pc_d;

  logic        valid0, valid1;
  logic [15:0] head_hw;
  logic        compressed;
  logic        pop, retire, push_ok;
  logic        unused_addr0;

  assign unused_addr0 = in_addr_i[0];

  assign valid0     = count_q != '0;
  assign valid1     = count_q >= CNT_W'(2);
  assign head_hw    = pc_q[1] ? rdata_q[0][31:16] : rdata_q[0][15:0];
  assign compressed = RV32C && is_compressed_opc(head_hw[1:0]);

  // Realignment mux. A straddling instruction whose first half already
  // faulted is released without waiting for the second word; the upper
  // half is then forced to zero so no stale data leaks out.
  always_comb begin
    out_rdata_o     = rdata_q[0];
    out_valid_o     = valid0;
    out_err_o       = err_q[0];
    out_err_plus2_o = 1'b0;
    if (pc_q[1]) begin
      out_rdata_o = {(valid1 ? rdata_q[1][15:0] : 16'h0000), rdata_q[0][31:16]};
      if (!compressed) begin
        out_valid_o     = valid0 & (valid1 | err_q[0]);
        out_err_o       = err_q[0] | (err_q[1] & valid1);
        out_err_plus2_o = err_q[1] & ~err_q[0];
      end
    end
  end

  // entry0 retires once the popped instruction reaches its upper halfword;
  // an aligned compressed pop leaves entry0 in place.
  assign pop       = out_valid_o & out_ready_i;
  assign retire    = pop & (pc_q[1] | ~compressed);
  assign cnt_after = count_q - CNT_W'(retire);
  assign push_ok   = in_valid_i && (cnt_after != CNT_W'(DEPTH));
  assign count_d   = cnt_after + CNT_W'(push_ok);
  assign pc_d      = pop ? (pc_q + (compressed ? 32'd2 : 32'd4)) : pc_q;

  // Shift on retire, then write the incoming word into the lowest free slot.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      rdata_d[i] = retire ? rdata_q[i+1] : rdata_q[i];
      err_d[i]   = retire ? err_q[i+1]   : err_q[i];
    end
    rdata_d[DEPTH-1] = rdata_q[DEPTH-1];
    err_d[DEPTH-1]   = retire ? 1'b0 : err_q[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (CNT_W'(i) == cnt_after)) begin
        rdata_d[i] = in_rdata_i;
        err_d[i]   = in_err_i;
      end
    end
  end

  // ---- control state: occupancy, PC, error flags ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      pc_q    <= '0;
      err_q   <= '0;
    end else if (clear_i) begin
      count_q <= '0;
      pc_q    <= {in_addr_i[31:2], in_addr_i[1] & RV32C, 1'b0};
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // ---- data storage: contents of free entries are don't-care ----
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
  end

  assign count_o    = count_q;
  assign out_addr_o = pc_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_valid_i && !clear_i && !push_ok));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o |-> !$isunknown(out_rdata_o));
  assert property (@(posedge clk_i) DEPTH >= 2);

endmodule

// File: tb/tb_cve2_fetch_fifo.sv
module tb_cve2_fetch_fifo;

  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear, in_valid, in_err, ready;
  logic [31:0]   in_addr, in_rdata;
  logic [CW-1:0] count;
  logic          valid, err, err2;
  logic [31:0]   addr, rdata;

  logic          clear_w, vld_w, rdy_w;
  logic [CW-1:0] count_w;
  logic          valid_w, err_w, err2_w;
  logic [31:0]   addr_w, rdata_w;

  cve2_fetch_fifo #(.DEPTH(DEPTH), .RV32C(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_addr_i(in_addr),
    .in_valid_i(in_valid), .in_rdata_i(in_rdata), .in_err_i(in_err),
    .count_o(count), .out_valid_o(valid), .out_ready_i(ready),
    .out_addr_o(addr), .out_rdata_o(rdata), .out_err_o(err),
    .out_err_plus2_o(err2)
  );

  cve2_fetch_fifo #(.DEPTH(DEPTH), .RV32C(1'b0)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_w), .in_addr_i(in_addr),
    .in_valid_i(vld_w), .in_rdata_i(in_rdata), .in_err_i(in_err),
    .count_o(count_w), .out_valid_o(valid_w), .out_ready_i(rdy_w),
    .out_addr_o(addr_w), .out_rdata_o(rdata_w), .out_err_o(err_w),
    .out_err_plus2_o(err2_w)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of fetch words plus the head PC.
  typedef struct packed { logic [31:0] d; logic e; } wd_t;
  wd_t         mq[$];
  logic [31:0] mpc = 32'h0;

  // Expected outputs from the current model state. rt says whether popping
  // the head would consume the front word; mk selects the meaningful bits.
  function automatic void m_eval(output logic v, output logic c, output logic rt,
                                 output logic [31:0] rd, output logic [31:0] mk,
                                 output logic e, output logic e2);
    logic [15:0] h;
    logic        have1;
    v = 0; c = 0; rt = 0; rd = 0; mk = 0; e = 0; e2 = 0;
    if (mq.size() == 0) return;
    h     = mpc[1] ? mq[0].d[31:16] : mq[0].d[15:0];
    c     = (h[1:0] != 2'b11);
    have1 = (mq.size() >= 2);
    if (!mpc[1]) begin
      v = 1; rd = mq[0].d; mk = c ? 32'h0000FFFF : 32'hFFFFFFFF;
      e = mq[0].e; rt = !c;
    end else if (c) begin
      v = 1; rd = {16'h0, h}; mk = 32'h0000FFFF; e = mq[0].e; rt = 1;
    end else begin
      v  = have1 | mq[0].e;
      rd = {(have1 ? mq[1].d[15:0] : 16'h0), h};
      mk = have1 ? 32'hFFFFFFFF : 32'h0000FFFF;
      e  = mq[0].e | (have1 & mq[1].e);
      e2 = have1 & mq[1].e & ~mq[0].e;
      rt = 1;
    end
  endfunction

  task automatic model_step();
    logic v, c, rt, e, e2;
    logic [31:0] rd, mk;
    if (!rst_n) begin
      mq.delete(); mpc = 32'h0;
    end else if (clear) begin
      mq.delete(); mpc = {in_addr[31:1], 1'b0};
    end else begin
      m_eval(v, c, rt, rd, mk, e, e2);
      if (v && ready) begin
        mpc = mpc + (c ? 32'd2 : 32'd4);
        if (rt) void'(mq.pop_front());
      end
      if (in_valid && mq.size() < DEPTH) mq.push_back('{in_rdata, in_err});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc(input logic cl, input logic [31:0] a, input logic v,
                     input logic [31:0] d, input logic e, input logic r);
    clear = cl; in_addr = a; in_valid = v; in_rdata = d; in_err = e; ready = r;
    step();
  endtask

  // Compare process: DUT against the model on every cycle.
  always @(negedge clk) begin : compare
    logic v, c, rt, e, e2;
    logic [31:0] rd, mk;
    if (chk_en) begin
      m_eval(v, c, rt, rd, mk, e, e2);
      chk("count", 32'(count), 32'(mq.size()));
      chk("valid", 32'(valid), 32'(v));
      chk("addr", addr, mpc);
      if (v) begin
        chk("rdata", rdata & mk, rd & mk);
        chk("err", 32'(err), 32'(e));
        chk("err_plus2", 32'(err2), 32'(e2));
      end
    end
  end

  initial begin
    logic        v, c, rt, e, e2, r, pv, cl;
    logic [31:0] rd, mk, d, a;
    rst_n = 1; clear = 0; in_addr = 0; in_valid = 0; in_rdata = 0; in_err = 0;
    ready = 0; clear_w = 0; vld_w = 0; rdy_w = 0;
    #1 rst_n = 0;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_plus2", 32'(err2), 32'd0);
    chk("rst_w_count", 32'(count_w), 32'd0);
    rst_n = 1;
    step();
    chk_en = 1'b1;

    // aligned 32-bit instruction
    cyc(1, 32'h80, 0, 0, 0, 0);
    chk("t1_clear_addr", addr, 32'h80);
    cyc(0, 0, 1, 32'h00000513, 0, 0);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_rdata", rdata, 32'h00000513);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_pop_addr", addr, 32'h84);
    chk("t1_pop_count", 32'(count), 32'd0);

    // two compressed instructions in one word
    cyc(1, 32'h80, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h45014501, 0, 0);
    chk("t2_rdata_lo", rdata & 32'hFFFF, 32'h4501);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t2_addr2", addr, 32'h82);
    chk("t2_count_kept", 32'(count), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t2_addr3", addr, 32'h84);
    chk("t2_count_ret", 32'(count), 32'd0);

    // straddling instruction waits for the second word
    cyc(1, 32'h82, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h05134501, 0, 0);
    chk("t3_wait_valid", 32'(valid), 32'd0);
    cyc(0, 0, 1, 32'h00000000, 0, 0);
    chk("t3_straddle_valid", 32'(valid), 32'd1);
    chk("t3_straddle_rdata", rdata, 32'h00000513);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_addr", addr, 32'h86);
    chk("t3_count", 32'(count), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_addr2", addr, 32'h88);

    // straddle errors: second word faulted, then first word faulted
    cyc(1, 32'h82, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h00134501, 0, 0);
    cyc(0, 0, 1, 32'h00000000, 1, 0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_err_plus2", 32'(err2), 32'd1);
    cyc(1, 32'h82, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h00130000, 1, 0);
    chk("t4b_valid", 32'(valid), 32'd1);
    chk("t4b_err", 32'(err), 32'd1);
    chk("t4b_err_plus2", 32'(err2), 32'd0);

    // full FIFO with push plus retiring pop, then clear with push and pop
    cyc(1, 32'h100, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h00000013, 0, 0);
    chk("t5_full", 32'(count), 32'd3);
    cyc(0, 0, 1, 32'h11111113, 0, 1);
    chk("t5_count_hold", 32'(count), 32'd3);
    chk("t5_addr", addr, 32'h104);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t5_no_loss", rdata, 32'h11111113);
    cyc(0, 0, 1, 32'h00000013, 0, 0);
    cyc(0, 0, 1, 32'h00000013, 0, 0);
    cyc(1, 32'h200, 1, 32'h00000013, 0, 1);
    chk("t5_clr_count", 32'(count), 32'd0);
    chk("t5_clr_addr", addr, 32'h200);
    chk("t5_clr_valid", 32'(valid), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);

    // word-aligned only instance
    in_addr = 32'h102; clear_w = 1; step(); clear_w = 0;
    chk("w_addr", addr_w, 32'h100);
    vld_w = 1; in_rdata = 32'h00004501; step();
    chk("w_valid", 32'(valid_w), 32'd1);
    chk("w_rdata", rdata_w, 32'h00004501);
    in_rdata = 32'h00000513; rdy_w = 1; step();
    chk("w_addr2", addr_w, 32'h104);
    chk("w_count", 32'(count_w), 32'd1);
    chk("w_rdata2", rdata_w, 32'h00000513);
    vld_w = 0; step();
    chk("w_addr3", addr_w, 32'h108);
    chk("w_count2", 32'(count_w), 32'd0);
    rdy_w = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      m_eval(v, c, rt, rd, mk, e, e2);
      r  = ($urandom_range(0, 9) < 7);
      pv = ((mq.size() < DEPTH) || (r && v && rt)) && ($urandom_range(0, 9) < 6);
      d  = $urandom;
      if ($urandom_range(0, 1) == 1) d[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) d[17:16] = 2'b11;
      e  = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 63) == 0);
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      cyc(cl, a, pv, d, e, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
